// File: rtl/rf_read_arbiter_if.sv
// ---------------------------------------------------------------------------
// rf_read_arbiter_if
//
// Bundles the requester side and the register-file side of the read
// arbiter into one interface.
//
//   req_en    requester -> arbiter   per-channel read enable (level)
//   req_addr  requester -> arbiter   per-channel address, channel i at
//                                    [i*REG_ADDR_LEN +: REG_ADDR_LEN]
//   req_data  arbiter -> requester   per-channel returned data, same packing
//   req_st    arbiter -> requester   per-channel one-cycle done strobe
//   flush     requester -> arbiter   cancel all pending and in-flight reads
//   rf_addr   arbiter -> regfile     read address
//   rf_en     arbiter -> regfile     read enable
//   rf_data   regfile -> arbiter     read data
//   busy      arbiter -> requester   arbiter FSM not idle
//
// The slave modport is the arbiter's view; master is the environment's view.
// ---------------------------------------------------------------------------
interface rf_read_arbiter_if #(
    parameter int WIDTH        = 32,
    parameter int REG_ADDR_LEN = 5,
    parameter int N_REQ        = 3
);
    logic [N_REQ-1:0]              req_en;
    logic [N_REQ*REG_ADDR_LEN-1:0] req_addr;
    logic [N_REQ*WIDTH-1:0]        req_data;
    logic [N_REQ-1:0]              req_st;
    logic                          flush;
    logic [REG_ADDR_LEN-1:0]       rf_addr;
    logic                          rf_en;
    logic [WIDTH-1:0]              rf_data;
    logic                          busy;

    modport master (
        output req_en, req_addr, flush, rf_data,
        input  req_data, req_st, rf_addr, rf_en, busy
    );

    modport slave (
        input  req_en, req_addr, flush, rf_data,
        output req_data, req_st, rf_addr, rf_en, busy
    );
endinterface

// File: rtl/rf_read_arbiter.sv
// ---------------------------------------------------------------------------
// rf_read_arbiter
//
// Shares the single register-file read port between N_REQ requesters
// (0 = Rd1, 1 = Rd2, 2 = aux). Each requester's level enable plus address
// is turned into a single read request on a rising enable or an address
// change; requests are served round-robin through a four-state FSM
// (IDLE -> ISSUE -> WAIT x RF_LAT -> DONE) and answered with a one-cycle
// done strobe plus held return data. A flush cancels everything pending.
//
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    rf_read_arbiter_if.slave: req_en/req_addr/flush/rf_data in,
//          req_data/req_st/rf_addr/rf_en/busy out
// ---------------------------------------------------------------------------
module rf_read_arbiter #(
    parameter int WIDTH        = 32,
    parameter int REG_ADDR_LEN = 5,
    parameter int N_REQ        = 3,
    parameter int RF_LAT       = 1
) (
    input logic              clk,
    input logic              rst_n,
    rf_read_arbiter_if.slave bus
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = 3;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t                  state_q, state_d;
    logic [N_REQ-1:0]        pend_q, pend_d;
    logic [IDX_W-1:0]        last_q, last_d;
    logic [IDX_W-1:0]        gnt_q, gnt_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic [N_REQ-1:0]        evt;
    logic [N_REQ-1:0]        cand;
    logic [REG_ADDR_LEN-1:0] addr_sel [N_REQ];
    logic                    capture;
    logic                    rr_found;
    logic [IDX_W-1:0]        rr_idx;
    logic                    rf_en_c;
    logic [REG_ADDR_LEN-1:0] rf_addr_c;

    // The data word is taken in the last WAIT cycle; a flush in that cycle
    // aborts the read, so the stored data is left untouched.
    assign capture = (state_q == WAIT) && (cnt_q == CNT_W'(RF_LAT)) && !bus.flush;

    // -----------------------------------------------------------------------
    // Per-channel request detection and data holding
    // -----------------------------------------------------------------------
    genvar gi;
    for (gi = 0; gi < N_REQ; gi++) begin : g_chan
        logic [REG_ADDR_LEN-1:0] addr_in;
        logic                    en_prev_q;
        logic [REG_ADDR_LEN-1:0] addr_prev_q;
        logic [REG_ADDR_LEN-1:0] addr_q;
        logic [WIDTH-1:0]        data_q;
        logic                    sel;

        assign addr_in = bus.req_addr[gi*REG_ADDR_LEN +: REG_ADDR_LEN];
        assign sel     = (gnt_q == IDX_W'(gi));

        // A held enable with a stable address is one request, not many.
        assign evt[gi] = bus.req_en[gi] && (!en_prev_q || (addr_in != addr_prev_q));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                en_prev_q   <= 1'b0;
                addr_prev_q <= '0;
                addr_q      <= '0;
                data_q      <= '0;
            end else begin
                // Detectors track the inputs even during flush, so a held
                // enable does not re-fire once the flush is over.
                en_prev_q   <= bus.req_en[gi];
                addr_prev_q <= addr_in;
                if (evt[gi] && !bus.flush) begin
                    addr_q <= addr_in;
                end
                if (capture && sel) begin
                    data_q <= bus.rf_data;
                end
            end
        end

        assign addr_sel[gi]                    = addr_q;
        assign bus.req_data[gi*WIDTH +: WIDTH] = data_q;
        assign bus.req_st[gi]                  = (state_q == DONE) && sel;
    end

    // -----------------------------------------------------------------------
    // Round-robin pick: first candidate after last, wrapping around.
    // Fresh events count as candidates so an idle arbiter issues the
    // cycle after the event.
    // -----------------------------------------------------------------------
    assign cand = pend_q | evt;

    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!rr_found && cand[i] && (IDX_W'(i) > last_q)) begin
                rr_found = 1'b1;
                rr_idx   = IDX_W'(i);
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!rr_found && cand[i] && (IDX_W'(i) <= last_q)) begin
                rr_found = 1'b1;
                rr_idx   = IDX_W'(i);
            end
        end
    end

    // -----------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pend_q  <= '0;
            last_q  <= IDX_W'(N_REQ - 1);
            gnt_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        last_d    = last_q;
        gnt_d     = gnt_q;
        cnt_d     = cnt_q;
        rf_en_c   = 1'b0;
        rf_addr_c = '0;

        case (state_q)
            IDLE: begin
                if (rr_found) begin
                    gnt_d   = rr_idx;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                rf_en_c        = 1'b1;
                rf_addr_c      = addr_sel[gnt_q];
                pend_d[gnt_q]  = 1'b0;
                last_d         = gnt_q;
                cnt_d          = CNT_W'(1);
                state_d        = WAIT;
            end
            WAIT: begin
                if (cnt_q == CNT_W'(RF_LAT)) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // New events win over the clear in ISSUE: a channel re-requesting
        // while in service is queued again with its new address.
        pend_d = pend_d | evt;

        // Flush wins over everything; a cancelled issue does not move the
        // round-robin pointer.
        if (bus.flush) begin
            pend_d    = '0;
            state_d   = IDLE;
            last_d    = last_q;
            gnt_d     = gnt_q;
            rf_en_c   = 1'b0;
            rf_addr_c = '0;
        end
    end

    assign bus.rf_en   = rf_en_c;
    assign bus.rf_addr = rf_addr_c;
    assign bus.busy    = (state_q != IDLE);

endmodule

// File: tb/tb_rf_read_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rf_read_arbiter
//
// Drives requests on the arbiter, models a register file with a one-cycle
// read latency, and checks strobe timing, grant order, flush and reset
// behaviour. Expected (channel, data) pairs are queued as requests are
// driven and popped whenever a done strobe appears.
// ---------------------------------------------------------------------------
module tb_rf_read_arbiter;

    localparam int WIDTH  = 32;
    localparam int RAL    = 5;
    localparam int N_REQ  = 3;
    localparam int RF_LAT = 1;

    typedef struct packed {
        logic [1:0]       ch;
        logic [WIDTH-1:0] data;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int checks   = 0;
    int failures = 0;

    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    rf_read_arbiter_if #(.WIDTH(WIDTH), .REG_ADDR_LEN(RAL), .N_REQ(N_REQ)) bus ();

    rf_read_arbiter #(
        .WIDTH(WIDTH), .REG_ADDR_LEN(RAL), .N_REQ(N_REQ), .RF_LAT(RF_LAT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Register-file contents as seen by the bench.
    function automatic logic [WIDTH-1:0] rf_val(input logic [RAL-1:0] a);
        if (a == 5'd5) return 32'hDEADBEEF;
        return 32'hC0DE0000 | (32'(a) << 8) | 32'(a);
    endfunction

    // Register-file model: data is valid only during the cycle after rf_en.
    logic           iss_seen = 1'b0;
    logic [RAL-1:0] iss_addr = '0;
    int unsigned    cyc      = 0;

    always @(posedge clk) begin
        iss_seen <= bus.rf_en;
        iss_addr <= bus.rf_addr;
        cyc      <= cyc + 1;
    end

    always @(negedge clk) begin
        bus.rf_data <= iss_seen ? rf_val(iss_addr) : (32'h5A5A0000 | {16'h0, cyc[15:0]});
    end

    // Scoreboard: every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (bus.req_st[i] === 1'b1) begin
                    checks++;
                    if (sb.size() == 0) begin
                        failures++;
                        $display("FAIL sb_unexpected_strobe ch=%0d data=%h required=no strobe",
                                 i, bus.req_data[i*WIDTH +: WIDTH]);
                    end else begin
                        mon_e = sb.pop_front();
                        if (int'(mon_e.ch) != i || bus.req_data[i*WIDTH +: WIDTH] !== mon_e.data) begin
                            failures++;
                            $display("FAIL sb_data got ch=%0d data=%h required ch=%0d data=%h",
                                     i, bus.req_data[i*WIDTH +: WIDTH], mon_e.ch, mon_e.data);
                        end else begin
                            $display("txn t=%0t ch=%0d data=%h", $time, i, mon_e.data);
                        end
                    end
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        bus.req_en = '0;
        bus.flush  = 1'b0;
        rst_n      = 1'b0;
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        bus.req_en   = '0;
        bus.req_addr = '0;
        bus.flush    = 1'b0;
        rst_n        = 1'b0;
        #1;
        checks++;
        if (bus.rf_en !== 1'b0) begin
            failures++; $display("FAIL reset_rf_en got=%b required=0", bus.rf_en);
        end
        checks++;
        if (bus.rf_addr !== '0) begin
            failures++; $display("FAIL reset_rf_addr got=%0d required=0", bus.rf_addr);
        end
        checks++;
        if (bus.req_st !== '0) begin
            failures++; $display("FAIL reset_req_st got=%b required=000", bus.req_st);
        end
        checks++;
        if (bus.req_data !== '0) begin
            failures++; $display("FAIL reset_req_data got=%h required=0", bus.req_data);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++; $display("FAIL reset_busy got=%b required=0", bus.busy);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        int             en_cnt  = 0;
        int             en_k    = -1;
        int             st_cnt  = 0;
        int             st_k    = -1;
        int             busy_hi = 0;
        logic [RAL-1:0] en_addr = '0;
        do_reset();
        bus.req_addr[0 +: RAL] = 5'd5;
        bus.req_en[0]          = 1'b1;
        sb.push_back('{ch: 2'd0, data: rf_val(5'd5)});
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (bus.rf_en === 1'b1) begin en_cnt++; en_k = k; en_addr = bus.rf_addr; end
            if (bus.req_st[0] === 1'b1) begin st_cnt++; st_k = k; end
            if (k <= 3 && bus.busy === 1'b1) busy_hi++;
        end
        bus.req_en[0] = 1'b0;
        checks++;
        if (en_cnt != 1 || en_k != 1) begin
            failures++; $display("FAIL single_rf_en_timing got count=%0d cycle=%0d required count=1 cycle=1", en_cnt, en_k);
        end
        checks++;
        if (en_addr !== 5'd5) begin
            failures++; $display("FAIL single_rf_addr got=%0d required=5", en_addr);
        end
        checks++;
        if (st_cnt != 1 || st_k != 3) begin
            failures++; $display("FAIL single_st_timing got count=%0d cycle=%0d required count=1 cycle=3", st_cnt, st_k);
        end
        checks++;
        if (busy_hi != 3) begin
            failures++; $display("FAIL single_busy got=%0d busy cycles required=3", busy_hi);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (bus.req_data[0 +: WIDTH] !== 32'hDEADBEEF) begin
            failures++; $display("FAIL single_data_held got=%h required=deadbeef", bus.req_data[0 +: WIDTH]);
        end
        checks++;
        if (sb.size() != 0) begin
            failures++; $display("FAIL single_sb_drained got=%0d left required=0", sb.size());
        end
    endtask

    task automatic test_two();
        int             en_k[$];
        logic [RAL-1:0] en_a[$];
        int             st0_k = -1;
        int             st1_k = -1;
        do_reset();
        bus.req_addr[0 +: RAL]   = 5'd3;
        bus.req_addr[RAL +: RAL] = 5'd7;
        bus.req_en[1:0]          = 2'b11;
        sb.push_back('{ch: 2'd0, data: rf_val(5'd3)});
        sb.push_back('{ch: 2'd1, data: rf_val(5'd7)});
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (bus.rf_en === 1'b1) begin en_k.push_back(k); en_a.push_back(bus.rf_addr); end
            if (bus.req_st[0] === 1'b1) st0_k = k;
            if (bus.req_st[1] === 1'b1) st1_k = k;
        end
        bus.req_en = '0;
        checks++;
        if (en_k.size() != 2 || en_k[0] != 1 || en_k[1] != 5) begin
            failures++; $display("FAIL two_issue_cycles got n=%0d first=%0d second=%0d required n=2 first=1 second=5",
                                 en_k.size(), (en_k.size() > 0) ? en_k[0] : -1, (en_k.size() > 1) ? en_k[1] : -1);
        end
        checks++;
        if (en_a.size() != 2 || en_a[0] !== 5'd3 || en_a[1] !== 5'd7) begin
            failures++; $display("FAIL two_issue_addr got n=%0d required addresses 3 then 7", en_a.size());
        end
        checks++;
        if (st0_k != 3 || st1_k != 7) begin
            failures++; $display("FAIL two_strobe_cycles got st0=%0d st1=%0d required st0=3 st1=7", st0_k, st1_k);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++; $display("FAIL two_sb_drained got=%0d left required=0", sb.size());
        end
    endtask

    task automatic test_round_robin();
        int             order[$];
        int             busy_lo = 0;
        int             nserv   = 0;
        int             bad     = 0;
        logic [RAL-1:0] a;
        do_reset();
        bus.req_addr[0 +: RAL]     = 5'd1;
        bus.req_addr[RAL +: RAL]   = 5'd2;
        bus.req_addr[2*RAL +: RAL] = 5'd4;
        bus.req_en                 = 3'b111;
        sb.push_back('{ch: 2'd0, data: rf_val(5'd1)});
        sb.push_back('{ch: 2'd1, data: rf_val(5'd2)});
        sb.push_back('{ch: 2'd2, data: rf_val(5'd4)});
        for (int k = 1; k <= 40 && nserv < 6; k++) begin
            @(negedge clk);
            if (k > 1 && bus.busy === 1'b0) busy_lo++;
            for (int i = 0; i < N_REQ; i++) begin
                if (bus.req_st[i] === 1'b1) begin
                    order.push_back(i);
                    nserv++;
                    if (nserv <= 3) begin
                        a = bus.req_addr[i*RAL +: RAL] ^ 5'd16;
                        bus.req_addr[i*RAL +: RAL] = a;
                        sb.push_back('{ch: 2'(i), data: rf_val(a)});
                    end
                end
            end
        end
        bus.req_en = '0;
        for (int j = 0; j < 6; j++) begin
            if (j >= order.size() || order[j] != (j % 3)) bad++;
        end
        checks++;
        if (bad != 0 || order.size() != 6) begin
            failures++; $display("FAIL rr_order got n=%0d wrong=%0d required order 0,1,2,0,1,2", order.size(), bad);
        end
        checks++;
        if (busy_lo != 5) begin
            failures++; $display("FAIL rr_idle_gaps got=%0d idle cycles required=5", busy_lo);
        end
        repeat (6) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++; $display("FAIL rr_sb_drained got=%0d left required=0", sb.size());
        end
    endtask

    task automatic test_held();
        int             en_cnt = 0;
        int             st_cnt = 0;
        logic [RAL-1:0] en_addr = '0;
        do_reset();
        bus.req_addr[RAL +: RAL] = 5'd9;
        bus.req_en[1]            = 1'b1;
        sb.push_back('{ch: 2'd1, data: rf_val(5'd9)});
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus.rf_en === 1'b1) en_cnt++;
            if (bus.req_st[1] === 1'b1) st_cnt++;
        end
        checks++;
        if (en_cnt != 1 || st_cnt != 1) begin
            failures++; $display("FAIL held_single_service got rf_en=%0d st=%0d required 1 and 1", en_cnt, st_cnt);
        end
        en_cnt = 0;
        st_cnt = 0;
        bus.req_addr[RAL +: RAL] = 5'd10;
        sb.push_back('{ch: 2'd1, data: rf_val(5'd10)});
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (bus.rf_en === 1'b1) begin en_cnt++; en_addr = bus.rf_addr; end
            if (bus.req_st[1] === 1'b1) st_cnt++;
        end
        bus.req_en = '0;
        checks++;
        if (en_cnt != 1 || st_cnt != 1 || en_addr !== 5'd10) begin
            failures++; $display("FAIL held_addr_change got rf_en=%0d st=%0d addr=%0d required 1, 1, addr 10",
                                 en_cnt, st_cnt, en_addr);
        end
    endtask

    task automatic test_flush();
        int             late_act = 0;
        int             busy_hi  = 0;
        logic           iss_ok;
        do_reset();
        bus.req_addr[0 +: RAL]     = 5'd6;
        bus.req_addr[2*RAL +: RAL] = 5'd12;
        bus.req_en                 = 3'b101;
        @(negedge clk);
        iss_ok = (bus.rf_en === 1'b1) && (bus.rf_addr === 5'd6);
        checks++;
        if (!iss_ok) begin
            failures++; $display("FAIL flush_pre_issue got rf_en=%b addr=%0d required rf_en=1 addr=6", bus.rf_en, bus.rf_addr);
        end
        @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        for (int k = 3; k <= 12; k++) begin
            if (bus.rf_en !== 1'b0 || bus.req_st !== '0) late_act++;
            if (bus.busy !== 1'b0) busy_hi++;
            @(negedge clk);
        end
        checks++;
        if (late_act != 0) begin
            failures++; $display("FAIL flush_no_activity got=%0d active cycles required=0", late_act);
        end
        checks++;
        if (busy_hi != 0) begin
            failures++; $display("FAIL flush_idle got=%0d busy cycles required=0", busy_hi);
        end
        checks++;
        if (bus.req_data !== '0) begin
            failures++; $display("FAIL flush_data_unchanged got=%h required=0", bus.req_data);
        end
        bus.req_en = '0;
    endtask

    task automatic test_reset_mid();
        int             en_k[$];
        logic [RAL-1:0] en_a[$];
        int             st2_k = -1;
        int             en1_k = -1;
        logic [RAL-1:0] en1_a = '0;
        do_reset();
        bus.req_addr[0 +: RAL] = 5'd5;
        bus.req_en[0]          = 1'b1;
        sb.push_back('{ch: 2'd0, data: rf_val(5'd5)});
        repeat (6) @(negedge clk);
        bus.req_en[0] = 1'b0;
        checks++;
        if (bus.req_data[0 +: WIDTH] !== 32'hDEADBEEF) begin
            failures++; $display("FAIL rmid_pre_data got=%h required=deadbeef", bus.req_data[0 +: WIDTH]);
        end
        bus.req_addr[RAL +: RAL] = 5'd8;
        bus.req_en[1]            = 1'b1;
        repeat (2) @(negedge clk);
        rst_n      = 1'b0;
        bus.req_en = '0;
        #1;
        checks++;
        if (bus.rf_en !== 1'b0 || bus.rf_addr !== '0 || bus.req_st !== '0 || bus.busy !== 1'b0 || bus.req_data !== '0) begin
            failures++; $display("FAIL rmid_async_clear got rf_en=%b rf_addr=%0d st=%b busy=%b data=%h required all zero",
                                 bus.rf_en, bus.rf_addr, bus.req_st, bus.busy, bus.req_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus.req_addr[0 +: RAL]     = 5'd30;
        bus.req_addr[2*RAL +: RAL] = 5'd31;
        bus.req_en                 = 3'b101;
        sb.push_back('{ch: 2'd0, data: rf_val(5'd30)});
        sb.push_back('{ch: 2'd2, data: rf_val(5'd31)});
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (bus.rf_en === 1'b1) begin en_k.push_back(k); en_a.push_back(bus.rf_addr); end
            if (bus.req_st[2] === 1'b1) st2_k = k;
        end
        bus.req_en = '0;
        checks++;
        if (en_a.size() != 2 || en_a[0] !== 5'd30 || en_a[1] !== 5'd31 || en_k[0] != 1 || en_k[1] != 5 || st2_k != 7) begin
            failures++; $display("FAIL rmid_priority_restart got n=%0d st2=%0d required ch0 (30) at 1, ch2 (31) at 5, st2 at 7",
                                 en_a.size(), st2_k);
        end
        repeat (2) @(negedge clk);
        bus.req_en[2] = 1'b1;
        sb.push_back('{ch: 2'd2, data: rf_val(5'd31)});
        st2_k = -1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (bus.rf_en === 1'b1) begin en1_k = k; en1_a = bus.rf_addr; end
            if (bus.req_st[2] === 1'b1) st2_k = k;
        end
        bus.req_en = '0;
        checks++;
        if (en1_k != 1 || en1_a !== 5'd31 || st2_k != 3) begin
            failures++; $display("FAIL rmid_ch2_latency got issue=%0d addr=%0d st=%0d required issue=1 addr=31 st=3",
                                 en1_k, en1_a, st2_k);
        end
    endtask

    initial begin
        bus.req_en   = '0;
        bus.req_addr = '0;
        bus.flush    = 1'b0;
        test_reset();
        test_single();
        test_two();
        test_round_robin();
        test_held();
        test_flush();
        test_reset_mid();
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++; $display("FAIL final_sb_drained got=%0d left required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
